// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared constants and helpers for the multi-lane TMDS encoder.
//   SYM_W / BYTE_W     : encoded symbol width and pixel byte width
//   CTRL_TOKEN_xx      : the four DVI control-period tokens, indexed by (C1,C0)
//   popcount8()        : number of ones in a byte
//   tmds_minimise()    : stage-1 transition-minimised word q_m[8:0]
//   tmds_ctrl_token()  : maps a (C1,C0) pair to its 10-bit control token
// -----------------------------------------------------------------------------
package tmds_pkg;

   localparam int SYM_W  = 10;
   localparam int BYTE_W = 8;

   localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'h354;
   localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
   localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'h154;
   localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

   function automatic logic [3:0] popcount8(input logic [BYTE_W-1:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < BYTE_W; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   // XNOR chaining is chosen for bytes heavy in ones (or exactly balanced
   // with a zero LSB) so that the resulting word has fewer transitions.
   // Bit 8 records which chaining was used so the receiver can undo it.
   function automatic logic [8:0] tmds_minimise(input logic [BYTE_W-1:0] d);
      logic       useXnor;
      logic [3:0] n;
      logic [8:0] q;
      n       = popcount8(d);
      useXnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
      q       = 9'd0;
      q[0]    = d[0];
      for (int i = 1; i < BYTE_W; i++) begin
         q[i] = useXnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = ~useXnor;
      return q;
   endfunction

   function automatic logic [SYM_W-1:0] tmds_ctrl_token(input logic [1:0] c);
      logic [SYM_W-1:0] t;
      case (c)
         2'b00:   t = CTRL_TOKEN_00;
         2'b01:   t = CTRL_TOKEN_01;
         2'b10:   t = CTRL_TOKEN_10;
         default: t = CTRL_TOKEN_11;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// -----------------------------------------------------------------------------
// tmds_lane_enc
// One TMDS lane: stage 1 registers the transition-minimised word and its
// ones count, stage 2 applies DC balancing (or emits a control token) and
// keeps this lane's private running disparity.
//   I_pix_clk : pixel clock
//   I_rst     : asynchronous active-high reset
//   I_de      : data enable (1 = pixel data, 0 = control period)
//   I_data    : pixel byte for this lane
//   I_ctl     : control pair (C1,C0) for this lane
//   O_tmds    : 10-bit encoded symbol, bit 0 transmitted first
//   O_disp    : running disparity after O_tmds, two's complement
// Latency from inputs to O_tmds/O_disp is two clocks.
// -----------------------------------------------------------------------------
module tmds_lane_enc
   import tmds_pkg::*;
#(
   parameter int DISP_W = 5
) (
   input  logic                     I_pix_clk,
   input  logic                     I_rst,
   input  logic                     I_de,
   input  logic [BYTE_W-1:0]        I_data,
   input  logic [1:0]               I_ctl,
   output logic [SYM_W-1:0]         O_tmds,
   output logic signed [DISP_W-1:0] O_disp
);

   localparam logic signed [DISP_W-1:0] ZERO = '0;
   localparam logic signed [DISP_W-1:0] TWO  = DISP_W'(2);
   localparam logic signed [DISP_W-1:0] FOUR = DISP_W'(4);

   logic [8:0]               w_qm;
   logic [8:0]               r_qm;
   logic [3:0]               r_n1;
   logic                     r_de;
   logic [1:0]               r_ctl;

   logic [SYM_W-1:0]         r_tmds;
   logic signed [DISP_W-1:0] r_cnt;

   logic signed [DISP_W-1:0] w_n1s;
   logic signed [DISP_W-1:0] w_half;
   logic signed [DISP_W-1:0] w_diff;
   logic signed [DISP_W-1:0] w_bias_inv;
   logic signed [DISP_W-1:0] w_bias_keep;
   logic                     w_cnt_pos;
   logic                     w_cnt_neg;
   logic [SYM_W-1:0]         w_sym;
   logic signed [DISP_W-1:0] w_cnt_next;

   assign w_qm = tmds_minimise(I_data);

   // Stage 1: transition-minimised word, its ones count, and the DE/ctl
   // pair delayed by one clock so they stay aligned with q_m.
   always_ff @(posedge I_pix_clk or posedge I_rst) begin
      if (I_rst) begin
         r_qm  <= '0;
         r_n1  <= '0;
         r_de  <= 1'b0;
         r_ctl <= 2'b00;
      end else begin
         r_qm  <= w_qm;
         r_n1  <= popcount8(w_qm[7:0]);
         r_de  <= I_de;
         r_ctl <= I_ctl;
      end
   end

   // N1-N0 = 2*(N1-4); forming (N1-4) first keeps every intermediate inside
   // a 5-bit signed range.
   assign w_n1s       = signed'({{(DISP_W-4){1'b0}}, r_n1});
   assign w_half      = w_n1s - FOUR;
   assign w_diff      = w_half + w_half;
   assign w_cnt_pos   = (r_cnt > ZERO);
   assign w_cnt_neg   = r_cnt[DISP_W-1];
   assign w_bias_inv  = r_qm[8] ? TWO : ZERO;
   assign w_bias_keep = r_qm[8] ? ZERO : TWO;

   // Stage 2: pick the symbol and the disparity update. A control period
   // always restarts the disparity from zero, so the first pixel after
   // blanking takes the balanced-start branch.
   always_comb begin
      w_sym      = tmds_ctrl_token(r_ctl);
      w_cnt_next = ZERO;
      if (r_de) begin
         if ((r_cnt == ZERO) || (r_n1 == 4'd4)) begin
            if (r_qm[8]) begin
               w_sym      = {2'b01, r_qm[7:0]};
               w_cnt_next = r_cnt + w_diff;
            end else begin
               w_sym      = {2'b10, ~r_qm[7:0]};
               w_cnt_next = r_cnt - w_diff;
            end
         end else if ((w_cnt_pos && (r_n1 > 4'd4)) ||
                      (w_cnt_neg && (r_n1 < 4'd4))) begin
            w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_next = r_cnt + w_bias_inv - w_diff;
         end else begin
            w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_next = r_cnt - w_bias_keep + w_diff;
         end
      end
   end

   // Stage 2 registers: symbol and disparity are captured together so the
   // reported disparity always belongs to the symbol on O_tmds.
   always_ff @(posedge I_pix_clk or posedge I_rst) begin
      if (I_rst) begin
         r_tmds <= CTRL_TOKEN_00;
         r_cnt  <= ZERO;
      end else begin
         r_tmds <= w_sym;
         r_cnt  <= w_cnt_next;
      end
   end

   assign O_tmds = r_tmds;
   assign O_disp = r_cnt;

endmodule

// File: rtl/tmds_encoder_mc.sv
// -----------------------------------------------------------------------------
// tmds_encoder_mc
// Multi-lane TMDS encoder: NUM_CH independent lanes sharing one data enable.
//   I_pix_clk : pixel clock, the only clock
//   I_rst     : asynchronous active-high reset
//   I_de      : data enable shared by all lanes
//   I_data    : pixel bytes, lane k on [8k+7:8k]
//   I_ctl     : control pairs (C1,C0), lane k on [2k+1:2k]
//   O_tmds    : encoded symbols, lane k on [10k+9:10k]
//   O_de      : I_de delayed two clocks, aligned with O_tmds
//   O_disp    : per-lane running disparity, lane k on [DISP_W*k +: DISP_W]
// -----------------------------------------------------------------------------
module tmds_encoder_mc
   import tmds_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int DISP_W = 5
) (
   input  logic                       I_pix_clk,
   input  logic                       I_rst,
   input  logic                       I_de,
   input  logic [BYTE_W*NUM_CH-1:0]   I_data,
   input  logic [2*NUM_CH-1:0]        I_ctl,
   output logic [SYM_W*NUM_CH-1:0]    O_tmds,
   output logic                       O_de,
   output logic [DISP_W*NUM_CH-1:0]   O_disp
);

   logic [1:0] r_de_d;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      tmds_lane_enc #(
         .DISP_W (DISP_W)
      ) u_lane (
         .I_pix_clk (I_pix_clk),
         .I_rst     (I_rst),
         .I_de      (I_de),
         .I_data    (I_data[BYTE_W*k +: BYTE_W]),
         .I_ctl     (I_ctl[2*k +: 2]),
         .O_tmds    (O_tmds[SYM_W*k +: SYM_W]),
         .O_disp    (O_disp[DISP_W*k +: DISP_W])
      );
   end

   // Two-deep DE delay matching the two lane pipeline stages.
   always_ff @(posedge I_pix_clk or posedge I_rst) begin
      if (I_rst) begin
         r_de_d <= 2'b00;
      end else begin
         r_de_d <= {r_de_d[0], I_de};
      end
   end

   assign O_de = r_de_d[1];

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// -----------------------------------------------------------------------------
// tb_tmds_encoder_mc
// Directed bench for the multi-lane TMDS encoder. A 3-lane instance is the
// main target; a 4-lane instance sees lane 0's byte/ctl on every lane.
// -----------------------------------------------------------------------------
module tb_tmds_encoder_mc;

   localparam int NCH = 3;
   localparam int DW  = 5;
   localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   logic              pixClk = 1'b0;
   logic              rst;
   logic              de;
   logic [8*NCH-1:0]  data;
   logic [2*NCH-1:0]  ctl;
   logic [10*NCH-1:0] tmds;
   logic              oDe;
   logic [DW*NCH-1:0] disp;

   logic [31:0]       data4;
   logic [7:0]        ctl4;
   logic [39:0]       tmds4;
   logic              oDe4;
   logic [DW*4-1:0]   disp4;

   int nChecks = 0;
   int nFails  = 0;
   int mCnt [NCH];

   assign data4 = {4{data[7:0]}};
   assign ctl4  = {4{ctl[1:0]}};

   always #5 pixClk = ~pixClk;

   tmds_encoder_mc #(.NUM_CH(NCH), .DISP_W(DW)) u_dut (
      .I_pix_clk (pixClk),
      .I_rst     (rst),
      .I_de      (de),
      .I_data    (data),
      .I_ctl     (ctl),
      .O_tmds    (tmds),
      .O_de      (oDe),
      .O_disp    (disp)
   );

   tmds_encoder_mc #(.NUM_CH(4), .DISP_W(DW)) u_dut4 (
      .I_pix_clk (pixClk),
      .I_rst     (rst),
      .I_de      (de),
      .I_data    (data4),
      .I_ctl     (ctl4),
      .O_tmds    (tmds4),
      .O_de      (oDe4),
      .O_disp    (disp4)
   );

   // Drive one set of inputs, let one rising edge pass, and return 1 time
   // unit later so outputs can be sampled away from the edge.
   task automatic applyStimulus(input logic e, input logic [8*NCH-1:0] d,
                                input logic [2*NCH-1:0] c);
      de   = e;
      data = d;
      ctl  = c;
      @(posedge pixClk);
      #1;
   endtask

   // Reference DVI 1.0 encoder for one lane, written from the algorithm
   // description with plain integers.
   task automatic modelStep(input logic [7:0] d, input logic e,
                            input logic [1:0] c, input int lane,
                            output logic [9:0] sym);
      int n1d, n1, n0;
      logic x;
      logic [8:0] q;
      if (!e) begin
         sym = TOK[c];
         mCnt[lane] = 0;
         return;
      end
      n1d  = $countones(d);
      x    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      q    = 9'd0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = x ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = !x;
      n1   = $countones(q[7:0]);
      n0   = 8 - n1;
      if (mCnt[lane] == 0 || n1 == n0) begin
         sym = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
         mCnt[lane] += q[8] ? (n1 - n0) : (n0 - n1);
      end else if ((mCnt[lane] > 0 && n1 > n0) || (mCnt[lane] < 0 && n0 > n1)) begin
         sym = {1'b1, q[8], ~q[7:0]};
         mCnt[lane] += 2 * int'(q[8]) + (n0 - n1);
      end else begin
         sym = {1'b0, q[8], q[7:0]};
         mCnt[lane] += -2 * int'(!q[8]) + (n1 - n0);
      end
   endtask

   function automatic logic [7:0] decodeSym(input logic [9:0] s);
      logic [7:0] q, b;
      q    = s[9] ? ~s[7:0] : s[7:0];
      b    = 8'd0;
      b[0] = q[0];
      for (int i = 1; i < 8; i++) b[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return b;
   endfunction

   // Outputs must sit at reset values while reset is held.
   task automatic test_reset();
      rst  = 1'b1;
      de   = 1'b0;
      data = '0;
      ctl  = '0;
      repeat (3) @(posedge pixClk);
      #1;
      for (int k = 0; k < NCH; k++) begin
         nChecks++;
         if (tmds[10*k +: 10] !== 10'h354) begin
            nFails++;
            $display("[TB] FAIL reset_tmds lane=%0d got=%h exp=354", k, tmds[10*k +: 10]);
         end
      end
      nChecks++;
      if (disp !== '0) begin
         nFails++;
         $display("[TB] FAIL reset_disp got=%h exp=0", disp);
      end
      nChecks++;
      if (oDe !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL reset_de got=%b exp=0", oDe);
      end
      nChecks++;
      if (tmds4 !== {4{10'h354}}) begin
         nFails++;
         $display("[TB] FAIL reset_tmds4 got=%h", tmds4);
      end
      rst = 1'b0;
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b0, '0, '0);
   endtask

   // Control tokens per lane, including lane 0 = 01 with others 00.
   task automatic test_ctl_tokens();
      logic [5:0] vc;
      int idx;
      for (int v = -1; v < 4; v++) begin
         vc = 6'b000001;
         if (v >= 0) begin
            for (int k = 0; k < NCH; k++) vc[2*k +: 2] = 2'((v + k) % 4);
         end
         applyStimulus(1'b0, '0, vc);
         applyStimulus(1'b0, '0, vc);
         for (int k = 0; k < NCH; k++) begin
            idx = (v < 0) ? ((k == 0) ? 1 : 0) : ((v + k) % 4);
            nChecks++;
            if (tmds[10*k +: 10] !== TOK[idx]) begin
               nFails++;
               $display("[TB] FAIL ctl_tmds v=%0d lane=%0d got=%h exp=%h", v, k, tmds[10*k +: 10], TOK[idx]);
            end
         end
         nChecks++;
         if (disp !== '0 || oDe !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ctl_disp_de v=%0d got disp=%h de=%b exp 0/0", v, disp, oDe);
         end
         idx = (v < 0) ? 1 : v;
         nChecks++;
         if (tmds4 !== {4{TOK[idx]}}) begin
            nFails++;
            $display("[TB] FAIL ctl_tmds4 v=%0d got=%h exp=%h x4", v, tmds4, TOK[idx]);
         end
      end
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b0, '0, '0);
   endtask

   // Two 0x00 pixels from zero disparity: 0x100 (-8) then 0x3FF (+2).
   task automatic test_zero_pair();
      logic [9:0] expS [3];
      int expD [3];
      logic signed [DW-1:0] g;
      expS = '{10'h100, 10'h3FF, 10'h354};
      expD = '{-8, 2, 0};
      applyStimulus(1'b1, '0, '0);
      for (int s = 0; s < 3; s++) begin
         applyStimulus(s == 0, '0, '0);
         for (int k = 0; k < NCH; k++) begin
            g = disp[DW*k +: DW];
            nChecks++;
            if (tmds[10*k +: 10] !== expS[s] || int'(g) != expD[s]) begin
               nFails++;
               $display("[TB] FAIL zero_pair s=%0d lane=%0d got=%h/%0d exp=%h/%0d", s, k, tmds[10*k +: 10], g, expS[s], expD[s]);
            end
         end
         for (int k = 0; k < 4; k++) begin
            g = disp4[DW*k +: DW];
            nChecks++;
            if (tmds4[10*k +: 10] !== expS[s] || int'(g) != expD[s]) begin
               nFails++;
               $display("[TB] FAIL zero_pair4 s=%0d lane=%0d got=%h/%0d exp=%h/%0d", s, k, tmds4[10*k +: 10], g, expS[s], expD[s]);
            end
         end
      end
      applyStimulus(1'b0, '0, '0);
   endtask

   // Long random line with occasional blanking, checked against the model.
   task automatic test_random_line();
      logic [7:0] curD [NCH], nxtD [NCH];
      logic [9:0] curS [NCH], nxtS [NCH];
      int curP [NCH], nxtP [NCH];
      logic curE, nxtE, ve;
      logic [8*NCH-1:0] vd;
      logic [2*NCH-1:0] vc;
      logic [9:0] gs;
      logic signed [DW-1:0] gd;
      for (int k = 0; k < NCH; k++) begin
         mCnt[k] = 0;
         curD[k] = '0;
         curS[k] = '0;
         curP[k] = 0;
      end
      curE = 1'b0;
      for (int t = 0; t <= 1000; t++) begin
         if (t < 1000) begin
            vd = (8*NCH)'($urandom);
            vc = (2*NCH)'($urandom);
            ve = ($urandom_range(15) != 0);
         end else begin
            vd = '0;
            vc = '0;
            ve = 1'b0;
         end
         for (int k = 0; k < NCH; k++) begin
            modelStep(vd[8*k +: 8], ve, vc[2*k +: 2], k, nxtS[k]);
            nxtP[k] = mCnt[k];
            nxtD[k] = vd[8*k +: 8];
         end
         nxtE = ve;
         applyStimulus(ve, vd, vc);
         if (t > 0) begin
            nChecks++;
            if (oDe !== curE) begin
               nFails++;
               $display("[TB] FAIL rnd_de t=%0d got=%b exp=%b", t, oDe, curE);
            end
            for (int k = 0; k < NCH; k++) begin
               gs = tmds[10*k +: 10];
               gd = disp[DW*k +: DW];
               nChecks++;
               if (gs !== curS[k]) begin
                  nFails++;
                  $display("[TB] FAIL rnd_sym t=%0d lane=%0d got=%h exp=%h", t, k, gs, curS[k]);
               end
               nChecks++;
               if (int'(gd) != curP[k]) begin
                  nFails++;
                  $display("[TB] FAIL rnd_disp t=%0d lane=%0d got=%0d exp=%0d", t, k, gd, curP[k]);
               end
               nChecks++;
               if (int'(gd) > 10 || int'(gd) < -10) begin
                  nFails++;
                  $display("[TB] FAIL rnd_range t=%0d lane=%0d got=%0d exp within +-10", t, k, gd);
               end
               if (curE) begin
                  nChecks++;
                  if (decodeSym(gs) !== curD[k]) begin
                     nFails++;
                     $display("[TB] FAIL rnd_decode t=%0d lane=%0d got=%h exp=%h", t, k, decodeSym(gs), curD[k]);
                  end
               end
            end
         end
         curS = nxtS;
         curP = nxtP;
         curD = nxtD;
         curE = nxtE;
      end
      applyStimulus(1'b0, '0, '0);
   endtask

   // DE toggling every cycle with ctl=11: data and 0x2AB alternate.
   task automatic test_toggle_de();
      logic [9:0] curS [NCH], nxtS [NCH];
      int curP [NCH], nxtP [NCH];
      logic curE, nxtE, ve;
      logic [8*NCH-1:0] vd;
      logic [2*NCH-1:0] vc;
      logic [9:0] gs;
      logic signed [DW-1:0] gd;
      for (int k = 0; k < NCH; k++) begin
         mCnt[k] = 0;
         curS[k] = '0;
         curP[k] = 0;
      end
      curE = 1'b0;
      for (int t = 0; t <= 40; t++) begin
         vd = (8*NCH)'($urandom);
         vc = (t < 40) ? '1 : '0;
         ve = (t < 40) && (t % 2 == 0);
         for (int k = 0; k < NCH; k++) begin
            modelStep(vd[8*k +: 8], ve, vc[2*k +: 2], k, nxtS[k]);
            nxtP[k] = mCnt[k];
         end
         nxtE = ve;
         applyStimulus(ve, vd, vc);
         if (t > 0) begin
            nChecks++;
            if (oDe !== curE) begin
               nFails++;
               $display("[TB] FAIL tog_de t=%0d got=%b exp=%b", t, oDe, curE);
            end
            for (int k = 0; k < NCH; k++) begin
               gs = tmds[10*k +: 10];
               gd = disp[DW*k +: DW];
               nChecks++;
               if (gs !== curS[k] || int'(gd) != curP[k]) begin
                  nFails++;
                  $display("[TB] FAIL tog_sym t=%0d lane=%0d got=%h/%0d exp=%h/%0d", t, k, gs, gd, curS[k], curP[k]);
               end
               if (!curE) begin
                  nChecks++;
                  if (gs !== 10'h2AB || gd !== '0) begin
                     nFails++;
                     $display("[TB] FAIL tog_ctl t=%0d lane=%0d got=%h/%0d exp=2ab/0", t, k, gs, gd);
                  end
               end
            end
         end
         curS = nxtS;
         curP = nxtP;
         curE = nxtE;
      end
      applyStimulus(1'b0, '0, '0);
   endtask

   // Reset mid-line with nonzero disparity clears outputs without a clock
   // edge, then encoding restarts from zero disparity.
   task automatic test_async_reset();
      logic signed [DW-1:0] g;
      applyStimulus(1'b1, '0, '0);
      applyStimulus(1'b1, '0, '0);
      g = disp[DW-1:0];
      nChecks++;
      if (tmds[9:0] !== 10'h100 || int'(g) != -8) begin
         nFails++;
         $display("[TB] FAIL arst_pre got=%h/%0d exp=100/-8", tmds[9:0], g);
      end
      #2;
      rst = 1'b1;
      #1;
      nChecks++;
      if (tmds !== {NCH{10'h354}} || disp !== '0 || oDe !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL arst_now got tmds=%h disp=%h de=%b exp 354s/0/0", tmds, disp, oDe);
      end
      nChecks++;
      if (tmds4 !== {4{10'h354}} || disp4 !== '0) begin
         nFails++;
         $display("[TB] FAIL arst_now4 got tmds=%h disp=%h", tmds4, disp4);
      end
      @(posedge pixClk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, '0, '0);
      nChecks++;
      if (tmds[9:0] !== 10'h354 || disp !== '0 || oDe !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL arst_hold got=%h/%h de=%b exp=354/0/0", tmds[9:0], disp, oDe);
      end
      applyStimulus(1'b0, '0, '0);
      g = disp[DW-1:0];
      nChecks++;
      if (tmds[9:0] !== 10'h100 || int'(g) != -8 || oDe !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL arst_resume got=%h/%0d de=%b exp=100/-8/1", tmds[9:0], g, oDe);
      end
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b0, '0, '0);
   endtask

   initial begin
      test_reset();
      test_ctl_tokens();
      test_zero_pair();
      test_random_line();
      test_toggle_de();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired before end of sequence");
      $fatal(1, "[TB] watchdog");
   end

endmodule
